decode_result_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares one 8-bit output link between several decoder controllers. Each controller emits fixed-length result packets: iteration count, 16-bit cycle count, then serialized correction bytes. The arbiter grants the link to one controller for a whole packet, so bytes from different decoders never interleave. It optionally prepends a source-ID byte. It sits between the per-decoder controllers' byte outputs and the host link.

---
 rtl/decode_result_arbiter.sv | 131 +++++++++++++
 tb/tb_decode_result_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_result_arbiter.sv
// Packet-atomic round-robin arbiter sharing one byte link between NUM_REQ decoder controllers.
// Define RESULT_ARB_SRC_HEADER_EN to prefix each packet with a {4'hE, id} source byte.
module decode_result_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PACKET_LEN = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [8*NUM_REQ-1:0]   in_data,
  input  logic [NUM_REQ-1:0]     in_valid,
  output logic [NUM_REQ-1:0]     in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             grant_id,
  output logic                   busy
);

  localparam int ID_WIDTH  = 4;
  localparam int CNT_WIDTH = $clog2(PACKET_LEN + 1);
  localparam int PTR_WIDTH = $clog2(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PACKET_LEN - 1);

`ifdef RESULT_ARB_SRC_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD} state_e;
`endif

  state_e                 state_q, state_d;
  logic [PTR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]    grant_q, grant_d;
  logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;

  logic                   pick_found;
  logic [ID_WIDTH-1:0]    pick_idx;
  logic [7:0]             sel_data;
  logic                   sel_valid;
  logic [PTR_WIDTH-1:0]   ptr_next;

  // Round-robin scan starting at rr_ptr, wrapping explicitly for non-power-of-2 counts.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && in_valid[cand[PTR_WIDTH-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data  = in_data[8*i +: 8];
        sel_valid = in_valid[i];
      end
    end
  end

  assign ptr_next = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : PTR_WIDTH'(grant_q + 4'd1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    byte_cnt_d = byte_cnt_q;
    out_valid  = 1'b0;
    out_data   = '0;
    in_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          byte_cnt_d = '0;
`ifdef RESULT_ARB_SRC_HEADER_EN
          state_d    = S_HEADER;
`else
          state_d    = S_PAYLOAD;
`endif
        end
      end
`ifdef RESULT_ARB_SRC_HEADER_EN
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = {4'hE, grant_q};
        if (out_ready) state_d = S_PAYLOAD;
      end
`endif
      S_PAYLOAD: begin
        // Grant is held through source bubbles; only the final byte releases it.
        out_data  = sel_data;
        out_valid = sel_valid;
        for (int i = 0; i < NUM_REQ; i++)
          in_ready[i] = (grant_q == ID_WIDTH'(i)) && out_ready;
        if (sel_valid && out_ready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_CNT) begin
            rr_ptr_d = ptr_next;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_decode_result_arbiter.sv
// Scoreboard bench for decode_result_arbiter: directed packets, expected bytes queued at issue time.
module tb_decode_result_arbiter;

`ifdef RESULT_ARB_SRC_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [3:0]  grant_id;
  logic        busy;

  logic [23:0] d2_in_data;
  logic [2:0]  d2_in_valid, d2_in_ready;
  logic [7:0]  d2_out_data;
  logic        d2_out_valid, d2_out_ready;
  logic [3:0]  d2_grant_id;
  logic        d2_busy;

  always #5 clk = ~clk;

  decode_result_arbiter #(.NUM_REQ(4), .PACKET_LEN(9)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy));

  decode_result_arbiter #(.NUM_REQ(3), .PACKET_LEN(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .out_data(d2_out_data), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .grant_id(d2_grant_id), .busy(d2_busy));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] src_mem [4][256];
  int         src_wr [4];
  int         src_rd [4];
  logic [3:0] hold;
  logic [3:0] fire_r;

  int exp_q[$];
  int xfer_cyc[$];
  int xfer_cnt = 0;
  int busy_cnt = 0;
  int bubble_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  logic d2_en = 1'b0;
  int   d2_j = 0;
  int   d2_last_pay = -1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requester models: a lane is valid while it has queued bytes and is not held.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_valid[i]       = (src_rd[i] != src_wr[i]) && !hold[i];
      in_data[8*i +: 8] = src_mem[i][src_rd[i]];
    end
  end

  always begin
    @(negedge clk);
    fire_r = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire_r[i]) src_rd[i] = src_rd[i] + 1;
  end

  // Monitor for the main instance.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0)
          check("extra_byte", int'({grant_id, out_data}), -1);
        else
          check("link_byte", int'({grant_id, out_data}), exp_q.pop_front());
      end
      if (busy) busy_cnt++;
      if (busy && !out_valid) bubble_cnt++;
      check("in_ready_onehot", int'($onehot0(in_ready)), 1);
      if (prev_stall) begin
        check("stall_hold_data", int'(out_data), int'(prev_data));
        check("stall_hold_valid", int'(out_valid), 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Monitor for the 3-requester, 1-byte-packet instance: all lanes always valid.
  always @(negedge clk) begin
    if (reset_n && d2_en && d2_j < 6*(1+H)) begin
      if (d2_out_valid) begin
        int pkt, pos, g;
        pkt = d2_j / (1+H);
        pos = d2_j % (1+H);
        g   = pkt % 3;
        if (H == 1 && pos == 0)
          check("d2_header", int'({d2_grant_id, d2_out_data}), (g << 8) | 8'hE0 | g);
        else begin
          check("d2_payload", int'({d2_grant_id, d2_out_data}), (g << 8) | (8'h10 + g));
          if (d2_last_pay >= 0) check("d2_packet_gap", cyc - d2_last_pay, 2 + H);
          d2_last_pay = cyc;
        end
        d2_j++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int lane, input int base);
    for (int k = 0; k < 9; k++) src_mem[lane][src_wr[lane] + k] = 8'(base + k);
    src_wr[lane] = src_wr[lane] + 9;
  endtask

  task automatic expect_pkt(input int g, input int base);
    if (H == 1) exp_q.push_back((g << 8) | 8'hE0 | g);
    for (int k = 0; k < 9; k++) exp_q.push_back((g << 8) | ((base + k) & 255));
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      tick();
      t++;
    end
    if (t >= budget) check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int t = 0;
    while (xfer_cnt < target && t < budget) begin
      tick();
      t++;
    end
    if (t >= budget) check("xfer_wait_timeout", xfer_cnt, target);
  endtask

  function automatic int span();
    if (xfer_cyc.size() == 0) return -1;
    return xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0] + 1;
  endfunction

  initial begin
    int busy_base, bub_base, mark, k;
    logic [3:0] pat;
    reset_n      = 1'b0;
    out_ready    = 1'b1;
    hold         = '0;
    for (int i = 0; i < 4; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    d2_in_data   = {8'h12, 8'h11, 8'h10};
    d2_in_valid  = 3'b111;
    d2_out_ready = 1'b1;
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_in_ready",  int'(in_ready), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_grant_id",  int'(grant_id), 0);
    check("rst_d2_in_ready", int'(d2_in_ready), 0);
    check("rst_d2_busy",   int'(d2_busy), 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    d2_en   = 1'b1;
    tick();

    // All four requesting together: order 0,1,2,3,0 with one idle cycle between packets.
    xfer_cyc.delete();
    busy_base = busy_cnt;
    load(0, 8'hA0); load(0, 8'hA9); load(1, 8'h20); load(2, 8'h40); load(3, 8'h60);
    expect_pkt(0, 8'hA0); expect_pkt(1, 8'h20); expect_pkt(2, 8'h40);
    expect_pkt(3, 8'h60); expect_pkt(0, 8'hA9);
    wait_done("all_four", 200);
    check("all_four_span", span(), 5*(9+H) + 4);
    check("all_four_busy", busy_cnt - busy_base, 5*(9+H));
    check("d2_done", d2_j, 6*(1+H));

    // Single requester 2, contiguous packet.
    tick();
    xfer_cyc.delete();
    busy_base = busy_cnt;
    load(2, 8'h01);
    expect_pkt(2, 8'h01);
    wait_done("single", 100);
    check("single_span", span(), 9 + H);
    check("single_busy", busy_cnt - busy_base, 9 + H);

    // rr_ptr now 3: requesters 0 and 3 together, 3 must win.
    tick();
    load(0, 8'h50); load(3, 8'h68);
    expect_pkt(3, 8'h68); expect_pkt(0, 8'h50);
    wait_done("rr_ptr3", 100);

    // Backpressure with out_ready pattern 1,0,0,1 on requester 1.
    tick();
    pat = 4'b1001;
    k = 0;
    load(1, 8'h30);
    expect_pkt(1, 8'h30);
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    if (k >= 200) check("backpressure_timeout", exp_q.size(), 0);
    out_ready = 1'b1;
    tick();

    // Requester 1 stalls 3 cycles mid-packet while requester 0 waits.
    bub_base = bubble_cnt;
    mark = xfer_cnt;
    load(1, 8'h70);
    expect_pkt(1, 8'h70);
    wait_xfers(mark + H + 4, 50);
    load(0, 8'h80);
    expect_pkt(0, 8'h80);
    hold[1] = 1'b1;
    repeat (3) tick();
    hold[1] = 1'b0;
    wait_done("stall", 100);
    check("stall_bubbles", bubble_cnt - bub_base, 3);

    // Reset mid-packet after 4 payload bytes of requester 2.
    tick();
    mark = xfer_cnt;
    load(2, 8'h90);
    expect_pkt(2, 8'h90);
    wait_xfers(mark + H + 4, 50);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data",  int'(out_data), 0);
    check("midrst_in_ready",  int'(in_ready), 0);
    check("midrst_busy",      int'(busy), 0);
    check("midrst_grant_id",  int'(grant_id), 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) src_wr[i] = src_rd[i];
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    load(0, 8'hC0); load(2, 8'hD0);
    expect_pkt(0, 8'hC0); expect_pkt(2, 8'hD0);
    wait_done("post_reset", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
